// File: rtl/pc_fetch_ctrl_if.sv
// Bundle of the fetch controller's redirect, instruction-memory and
// downstream instruction-handshake signals.
interface pc_fetch_ctrl_if;
  logic        redir_b;
  logic        redir_j;
  logic [31:0] br_value;
  logic [31:0] j_value;

  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;

  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  logic [15:0] flush_cnt;

  // Fetch controller side
  modport master (
    input  redir_b, redir_j, br_value, j_value,
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output if_valid, if_pc, if_instr,
    input  if_ready,
    output flush_cnt
  );

  // Environment side (memory, redirect source, decode stage)
  modport slave (
    output redir_b, redir_j, br_value, j_value,
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  if_valid, if_pc, if_instr,
    output if_ready,
    input  flush_cnt
  );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Program-counter / instruction-fetch controller. Issues one instruction
// memory request at a time, hands the returned word downstream, and
// discards responses made stale by branch/jump redirects.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter int unsigned PC_STEP    = 4
) (
  input  logic           clk,
  input  logic           rst,
  pc_fetch_ctrl_if.master bus
);

  localparam logic [31:0] STEP = 32'(PC_STEP);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_OUT,
    S_FLUSH
  } state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] req_addr, req_addr_n;
  logic        redir_pend, redir_pend_n;
  logic [31:0] instr_q, instr_n;
  logic [31:0] if_pc_q, if_pc_n;
  logic [15:0] flush_cnt_q;
  logic        discard;

  logic        redir;
  logic [31:0] target;

  // Branch redirect wins over jump redirect
  assign redir  = bus.redir_b | bus.redir_j;
  assign target = bus.redir_b ? bus.br_value : bus.j_value;

  // Next-state, next-PC and response-capture decisions
  always_comb begin
    state_n      = state;
    pc_n         = pc;
    redir_pend_n = redir_pend;
    instr_n      = instr_q;
    if_pc_n      = if_pc_q;
    discard      = 1'b0;
    unique case (state)
      S_IDLE: state_n = S_REQ;
      S_REQ: begin
        if (bus.imem_req_ready) begin
          redir_pend_n = 1'b0;
          if (redir_pend || redir) begin
            // pc already holds the pending target unless a newer one arrives now
            state_n = S_FLUSH;
            if (redir) pc_n = target;
          end else begin
            state_n = S_WAIT;
            pc_n    = req_addr + STEP;
          end
        end else if (redir) begin
          redir_pend_n = 1'b1;
          pc_n         = target;
        end
      end
      S_WAIT: begin
        if (redir) begin
          pc_n = target;
          if (bus.imem_rsp_valid) begin
            discard = 1'b1;
            state_n = S_REQ;
          end else begin
            state_n = S_FLUSH;
          end
        end else if (bus.imem_rsp_valid) begin
          instr_n = bus.imem_rsp_data;
          if_pc_n = req_addr;
          state_n = S_OUT;
        end
      end
      S_FLUSH: begin
        if (redir) pc_n = target;
        if (bus.imem_rsp_valid) begin
          discard = 1'b1;
          state_n = S_REQ;
        end
      end
      S_OUT: begin
        if (redir) begin
          pc_n    = target;
          state_n = S_REQ;
        end else if (bus.if_ready) begin
          state_n = S_REQ;
        end
      end
      default: state_n = S_IDLE;
    endcase
    // Latch the fetch address only when a new request begins, so it is stable while stalled
    req_addr_n = ((state_n == S_REQ) && (state != S_REQ)) ? pc_n : req_addr;
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      pc         <= RESET_ADDR;
      req_addr   <= RESET_ADDR;
      redir_pend <= 1'b0;
      instr_q    <= '0;
      if_pc_q    <= '0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      req_addr   <= req_addr_n;
      redir_pend <= redir_pend_n;
      instr_q    <= instr_n;
      if_pc_q    <= if_pc_n;
    end
  end

  // Saturating count of discarded memory responses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_cnt_q <= '0;
    end else if (discard && (flush_cnt_q != '1)) begin
      flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign bus.imem_req_valid = (state == S_REQ);
  assign bus.imem_req_addr  = req_addr;
  assign bus.if_valid       = (state == S_OUT);
  assign bus.if_pc          = if_pc_q;
  assign bus.if_instr       = instr_q;
  assign bus.flush_cnt      = flush_cnt_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: directed scenarios plus a
// randomized run compared against a transaction-level fetch model.
module tb_pc_fetch_ctrl;

  localparam logic [31:0] RST_ADDR = 32'h0000_0000;
  localparam logic [31:0] STEP     = 32'd4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pc_fetch_ctrl_if bus ();

  pc_fetch_ctrl #(.RESET_ADDR(32'h0000_0000), .PC_STEP(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  // Memory responder
  bit          mem_armed;
  int          mem_cnt;
  int          mem_lat = 1;
  logic [31:0] mem_addr;
  bit          spur;

  // Reference model: phase of the current fetch transaction
  bit          m_boot, m_req, m_wait, m_hold, m_taint;
  logic [31:0] m_next, m_addr, m_hpc, m_hinstr;
  logic [15:0] m_flush;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  task automatic model_reset();
    m_boot = 1; m_req = 0; m_wait = 0; m_hold = 0; m_taint = 0;
    m_next = RST_ADDR; m_addr = RST_ADDR; m_hpc = '0; m_hinstr = '0; m_flush = '0;
  endtask

  task automatic start_req();
    m_req = 1; m_addr = m_next; m_taint = 0;
  endtask

  // A fetch is delivered only if no redirect touched it between issue and response
  task automatic model_update();
    bit          rd;
    logic [31:0] tg;
    if (rst) begin model_reset(); return; end
    rd = bus.redir_b | bus.redir_j;
    tg = bus.redir_b ? bus.br_value : bus.j_value;
    if (m_boot) begin
      m_boot = 0;
      start_req();
    end else if (m_req) begin
      if (rd) begin m_next = tg; m_taint = 1; end
      if (bus.imem_req_ready) begin
        m_req = 0; m_wait = 1;
        if (!m_taint) m_next = m_addr + STEP;
      end
    end else if (m_wait) begin
      if (rd) begin m_next = tg; m_taint = 1; end
      if (bus.imem_rsp_valid) begin
        m_wait = 0;
        if (m_taint) begin
          if (m_flush != 16'hFFFF) m_flush = m_flush + 16'd1;
          start_req();
        end else begin
          m_hold = 1; m_hpc = m_addr; m_hinstr = bus.imem_rsp_data;
        end
      end
    end else if (m_hold) begin
      if (rd) begin m_next = tg; m_hold = 0; start_req(); end
      else if (bus.if_ready) begin m_hold = 0; start_req(); end
    end
  endtask

  task automatic set_in(input bit rdy, input bit irdy, input bit rb, input bit rj,
                        input logic [31:0] bv, input logic [31:0] jv);
    bus.imem_req_ready = rdy; bus.if_ready = irdy;
    bus.redir_b = rb; bus.redir_j = rj; bus.br_value = bv; bus.j_value = jv;
  endtask

  // One clock cycle: memory drives its response, then the edge, then sample point
  task automatic tick();
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = $urandom();
    if (mem_armed) begin
      if (mem_cnt <= 1) begin
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = mem_word(mem_addr);
        mem_armed = 0;
      end else begin
        mem_cnt--;
      end
    end else if (spur && !m_wait) begin
      bus.imem_rsp_valid = 1'b1;
    end
    if (bus.imem_req_valid === 1'b1 && bus.imem_req_ready === 1'b1) begin
      mem_armed = 1; mem_addr = bus.imem_req_addr; mem_cnt = mem_lat;
    end
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mem_armed = 0; spur = 0; mem_lat = 1;
    set_in(0, 0, 0, 0, '0, '0);
    bus.imem_rsp_valid = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    set_in(0, 0, 0, 0, '0, '0);
    bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = '0;
    rst = 1'b1; mem_armed = 0; spur = 0; model_reset();
    #1;
    checks++; if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid: got %b want 0", bus.imem_req_valid); end
    checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL rst_if_valid: got %b want 0", bus.if_valid); end
    checks++; if (bus.flush_cnt !== 16'h0) begin errors++; $display("FAIL rst_flush_cnt: got %h want 0", bus.flush_cnt); end
    checks++; if (bus.if_pc !== 32'h0) begin errors++; $display("FAIL rst_if_pc: got %h want 0", bus.if_pc); end
    checks++; if (bus.if_instr !== 32'h0) begin errors++; $display("FAIL rst_if_instr: got %h want 0", bus.if_instr); end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    checks++; if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL first_cycle_idle: got %b want 0", bus.imem_req_valid); end
    tick();
    checks++; if (bus.imem_req_valid !== 1'b1) begin errors++; $display("FAIL second_cycle_req: got %b want 1", bus.imem_req_valid); end
    checks++; if (bus.imem_req_addr !== RST_ADDR) begin errors++; $display("FAIL first_addr: got %h want %h", bus.imem_req_addr, RST_ADDR); end
  endtask

  task automatic test_seq_fetch();
    logic [31:0] e;
    int n, cyc, last;
    do_reset();
    set_in(1, 1, 0, 0, '0, '0);
    e = RST_ADDR; n = 0; cyc = 0; last = 0;
    for (int i = 0; i < 20 && n < 3; i++) begin
      tick(); cyc++;
      if (bus.if_valid === 1'b1) begin
        checks++; if (bus.if_pc !== e) begin errors++; $display("FAIL seq_pc: got %h want %h", bus.if_pc, e); end
        checks++; if (bus.if_instr !== mem_word(e)) begin errors++; $display("FAIL seq_instr: got %h want %h", bus.if_instr, mem_word(e)); end
        if (n > 0) begin
          checks++; if (cyc - last !== 3) begin errors++; $display("FAIL seq_throughput: got %0d cycles want 3", cyc - last); end
        end
        last = cyc; e = e + STEP; n++;
      end
    end
    checks++; if (n !== 3) begin errors++; $display("FAIL seq_timeout: got %0d instrs want 3", n); end
  endtask

  task automatic test_backpressure();
    do_reset();
    set_in(0, 1, 0, 0, '0, '0); tick();
    tick();
    checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h0) begin errors++; $display("FAIL bp_hold1: got v=%b a=%h want v=1 a=0", bus.imem_req_valid, bus.imem_req_addr); end
    set_in(0, 1, 0, 1, '0, 32'h100); tick();
    checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h0) begin errors++; $display("FAIL bp_hold2: got v=%b a=%h want v=1 a=0", bus.imem_req_valid, bus.imem_req_addr); end
    set_in(0, 1, 0, 0, '0, '0); tick();
    checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h0) begin errors++; $display("FAIL bp_hold3: got v=%b a=%h want v=1 a=0", bus.imem_req_valid, bus.imem_req_addr); end
    set_in(1, 1, 0, 0, '0, '0); tick();
    tick();
    checks++; if (bus.flush_cnt !== 16'd1) begin errors++; $display("FAIL bp_flush_cnt: got %0d want 1", bus.flush_cnt); end
    checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h100) begin errors++; $display("FAIL bp_redirect_addr: got v=%b a=%h want v=1 a=100", bus.imem_req_valid, bus.imem_req_addr); end
    checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL bp_if_valid: got %b want 0", bus.if_valid); end
  endtask

  task automatic test_priority();
    int found;
    do_reset();
    set_in(1, 0, 0, 0, '0, '0);
    found = 0;
    for (int i = 0; i < 10 && found == 0; i++) begin tick(); if (bus.if_valid === 1'b1) found = 1; end
    checks++; if (found == 0) begin errors++; $display("FAIL prio_timeout: got no if_valid want if_valid"); end
    tick();
    checks++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h0 || bus.if_instr !== mem_word(32'h0)) begin errors++; $display("FAIL prio_hold_stable: got v=%b pc=%h i=%h want v=1 pc=0 i=%h", bus.if_valid, bus.if_pc, bus.if_instr, mem_word(32'h0)); end
    set_in(1, 1, 1, 1, 32'h40, 32'h80); tick();
    checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL prio_drop: got if_valid=%b want 0", bus.if_valid); end
    checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h40) begin errors++; $display("FAIL prio_addr: got v=%b a=%h want v=1 a=40", bus.imem_req_valid, bus.imem_req_addr); end
    set_in(1, 1, 0, 0, '0, '0);
    found = 0;
    for (int i = 0; i < 10 && found == 0; i++) begin tick(); if (bus.if_valid === 1'b1) found = 1; end
    checks++; if (found == 0 || bus.if_pc !== 32'h40) begin errors++; $display("FAIL prio_next_pc: got found=%0d pc=%h want pc=40", found, bus.if_pc); end
    checks++; if (bus.flush_cnt !== 16'd0) begin errors++; $display("FAIL prio_flush_cnt: got %0d want 0", bus.flush_cnt); end
  endtask

  task automatic test_wait_redirect();
    int found;
    do_reset();
    set_in(1, 1, 0, 0, '0, '0); tick(); tick();
    set_in(1, 1, 0, 1, '0, 32'h200); tick();
    checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL wr_if_valid: got %b want 0", bus.if_valid); end
    checks++; if (bus.flush_cnt !== 16'd1) begin errors++; $display("FAIL wr_flush_cnt: got %0d want 1", bus.flush_cnt); end
    checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h200) begin errors++; $display("FAIL wr_addr: got v=%b a=%h want v=1 a=200", bus.imem_req_valid, bus.imem_req_addr); end
    set_in(1, 1, 0, 0, '0, '0);
    found = 0;
    for (int i = 0; i < 10 && found == 0; i++) begin tick(); if (bus.if_valid === 1'b1) found = 1; end
    checks++; if (found == 0 || bus.if_instr !== mem_word(32'h200)) begin errors++; $display("FAIL wr_instr: got found=%0d i=%h want %h", found, bus.if_instr, mem_word(32'h200)); end
  endtask

  task automatic test_wrap();
    do_reset();
    set_in(0, 1, 0, 0, '0, '0); tick();
    set_in(0, 1, 0, 1, '0, 32'hFFFF_FFFC); tick();
    set_in(1, 1, 0, 0, '0, '0); tick(); tick();
    checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_top_addr: got v=%b a=%h want v=1 a=fffffffc", bus.imem_req_valid, bus.imem_req_addr); end
    tick(); tick();
    checks++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_if_pc: got v=%b pc=%h want v=1 pc=fffffffc", bus.if_valid, bus.if_pc); end
    tick();
    checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h0) begin errors++; $display("FAIL wrap_next_addr: got v=%b a=%h want v=1 a=0", bus.imem_req_valid, bus.imem_req_addr); end
  endtask

  task automatic test_async_reset();
    do_reset();
    set_in(1, 0, 0, 0, '0, '0); tick();
    set_in(1, 0, 0, 1, '0, 32'h300); tick();
    set_in(1, 0, 0, 0, '0, '0); tick(); tick(); tick();
    checks++; if (bus.if_valid !== 1'b1 || bus.flush_cnt !== 16'd1) begin errors++; $display("FAIL ar_setup: got v=%b fc=%0d want v=1 fc=1", bus.if_valid, bus.flush_cnt); end
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL ar_if_valid: got %b want 0", bus.if_valid); end
    checks++; if (bus.flush_cnt !== 16'd0) begin errors++; $display("FAIL ar_flush_cnt: got %0d want 0", bus.flush_cnt); end
    mem_armed = 0; model_reset();
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    tick();
    checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== RST_ADDR) begin errors++; $display("FAIL ar_restart_addr: got v=%b a=%h want v=1 a=%h", bus.imem_req_valid, bus.imem_req_addr, RST_ADDR); end
  endtask

  task automatic test_random();
    logic [31:0] bv, jv;
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      bv = $urandom() & 32'hFFFF_FFFC;
      jv = $urandom() & 32'hFFFF_FFFC;
      set_in($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 6,
             !m_boot && ($urandom_range(0, 19) == 0), !m_boot && ($urandom_range(0, 14) == 0), bv, jv);
      mem_lat = $urandom_range(1, 3);
      spur = ($urandom_range(0, 9) == 0);
      tick();
      checks++; if (bus.imem_req_valid !== m_req) begin errors++; $display("FAIL rnd_req_valid @%0d: got %b want %b", i, bus.imem_req_valid, m_req); end
      if (m_req) begin
        checks++; if (bus.imem_req_addr !== m_addr) begin errors++; $display("FAIL rnd_req_addr @%0d: got %h want %h", i, bus.imem_req_addr, m_addr); end
      end
      checks++; if (bus.if_valid !== m_hold) begin errors++; $display("FAIL rnd_if_valid @%0d: got %b want %b", i, bus.if_valid, m_hold); end
      if (m_hold) begin
        checks++; if (bus.if_pc !== m_hpc) begin errors++; $display("FAIL rnd_if_pc @%0d: got %h want %h", i, bus.if_pc, m_hpc); end
        checks++; if (bus.if_instr !== m_hinstr) begin errors++; $display("FAIL rnd_if_instr @%0d: got %h want %h", i, bus.if_instr, m_hinstr); end
      end
      checks++; if (bus.flush_cnt !== m_flush) begin errors++; $display("FAIL rnd_flush_cnt @%0d: got %0d want %0d", i, bus.flush_cnt, m_flush); end
    end
    spur = 0;
  endtask

  initial begin
    test_reset();
    test_seq_fetch();
    test_backpressure();
    test_priority();
    test_wait_redirect();
    test_wrap();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
